// File: rtl/neuron_pkg.sv
// Shared types and helpers for the perceptron training loop.
package neuron_pkg;

    localparam int unsigned SAMPLE_W = 8;
    localparam int unsigned ERROR_W  = 16;

    typedef logic [SAMPLE_W-1:0]       sample_t;
    typedef logic signed [ERROR_W-1:0] error_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/target_fifo.sv
// Target buffer: valid/ready FIFO with registered count; a full FIFO refuses pushes
// even when a pop happens in the same cycle.
module target_fifo
    import neuron_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic    clock,
    input  logic    reset,
    input  logic    push_valid,
    output logic    push_ready,
    input  sample_t push_data,
    output logic    pop_valid,
    input  logic    pop_ready,
    output sample_t pop_data
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    sample_t         mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            full;
    logic            empty;
    logic            do_push;
    logic            do_pop;

    assign full       = (count == CW'(DEPTH));
    assign empty      = (count == '0);
    assign push_ready = !reset && !full;
    assign pop_valid  = !empty;
    assign pop_data   = mem[rd_ptr];
    assign do_push    = push_valid && push_ready;
    assign do_pop     = pop_ready && !empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/error_stage.sv
// Pairs perceptron results with buffered targets, returns the signed error and
// tracks per-epoch maximum |error| for the convergence flag.
module error_stage
    import neuron_pkg::*;
#(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned EPOCH     = 4,
    parameter int unsigned TOLERANCE = 5,
    parameter int unsigned SHIFT     = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        train,
    input  logic        target_valid,
    output logic        target_ready,
    input  logic [7:0]  target_data,
    input  logic        result_valid,
    output logic        result_ready,
    input  logic [7:0]  result_data,
    output logic        error_valid,
    input  logic        error_ready,
    output logic [15:0] error_data,
    output logic        epoch_done,
    output logic        converged,
    output logic [15:0] epochs
);

    localparam int unsigned CW  = (EPOCH > 1) ? $clog2(EPOCH) : 1;
    localparam sample_t     TOL = sample_t'((TOLERANCE > 255) ? 255 : TOLERANCE);

    generate
        if (SHIFT > 7) begin : g_bad_shift
            $error("error_stage: SHIFT must be in 0..7");
        end
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("error_stage: DEPTH must be a power of two >= 2");
        end
        if (EPOCH < 1) begin : g_bad_epoch
            $error("error_stage: EPOCH must be >= 1");
        end
    endgenerate

    sample_t            head;
    logic               fifo_valid;
    logic               pair;
    logic signed [8:0]  diff;
    error_t             shifted;
    sample_t            mag;
    sample_t            run_max;
    sample_t            max_next;
    logic [CW-1:0]      sample_cnt;
    logic               last;

    target_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .push_valid (target_valid),
        .push_ready (target_ready),
        .push_data  (target_data),
        .pop_valid  (fifo_valid),
        .pop_ready  (pair),
        .pop_data   (head)
    );

    // A new pair is taken only when the error slot is free or being drained.
    assign result_ready = !reset && fifo_valid && (!error_valid || error_ready);
    assign pair         = result_valid && result_ready;

    assign diff     = $signed({1'b0, head}) - $signed({1'b0, result_data});
    assign shifted  = error_t'(diff) <<< SHIFT;
    assign mag      = diff[8] ? 8'(-diff) : diff[7:0];
    assign max_next = (mag > run_max) ? mag : run_max;
    assign last     = (sample_cnt == CW'(EPOCH - 1));

    // Error register: held until accepted, replaced on the next pair.
    always_ff @(posedge clock) begin
        if (reset) begin
            error_valid <= 1'b0;
            error_data  <= '0;
        end else if (pair) begin
            error_valid <= train;
            error_data  <= shifted;
        end else if (error_valid && error_ready) begin
            error_valid <= 1'b0;
        end
    end

    // Epoch statistics advance on every pair, trained or not.
    always_ff @(posedge clock) begin
        if (reset) begin
            run_max    <= '0;
            sample_cnt <= '0;
            epoch_done <= 1'b0;
            converged  <= 1'b0;
            epochs     <= '0;
        end else begin
            epoch_done <= 1'b0;
            if (pair) begin
                if (last) begin
                    epoch_done <= 1'b1;
                    converged  <= (max_next <= TOL);
                    epochs     <= sat_inc16(epochs);
                    run_max    <= '0;
                    sample_cnt <= '0;
                end else begin
                    run_max    <= max_next;
                    sample_cnt <= sample_cnt + CW'(1);
                end
            end
        end
    end

endmodule
